// File: rtl/pulse_train_gen_pkg.sv
// Shared constants for the SN74XX93 pulse-train generator: FSM encodings, idle level, timer sizing.
package pulse_train_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_TAIL  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic PULSE_IDLE_LEVEL = 1'b1;

  // Bits needed to hold the largest phase-timer load value.
  function automatic int unsigned timer_width(int unsigned half, int unsigned clr);
    int unsigned m;
    m = (half > clr) ? half : clr;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Loadable down-counter; expire_c flags the last cycle of the current phase.
module pulse_train_gen_phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits N low-going pulses for an SN74XX93 counter, optionally clearing it first via r0/r1.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned HALF       = 1,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  input  logic             clear_first,
  output logic             ready,
  output logic             done,
  output logic             pulse_a,
  output logic             pulse_b,
  output logic             r0,
  output logic             r1,
  output logic [WIDTH-1:0] sent
);

  localparam int unsigned TW = timer_width(HALF, CLR_CYCLES);
  localparam logic [TW-1:0] HALF_LD      = TW'(HALF - 32'd1);
  // The final high half-period ends with the TAIL cycle, so its HIGH part is one shorter.
  localparam logic [TW-1:0] HALF_LAST_LD = TW'((HALF > 32'd1) ? (HALF - 32'd2) : 32'd0);
  localparam logic [TW-1:0] CLR_LD       = TW'(CLR_CYCLES - 32'd1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] sent_q, sent_d;
  logic             pulse_a_q, pulse_a_d;
  logic             pulse_b_q;
  logic             clr_q, clr_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_expire_c;
  logic             accept;
  logic             enter_low;

  pulse_train_gen_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire_c (tmr_expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count == '0)      state_d = ST_DONE;
          else if (clear_first) state_d = ST_CLEAR;
          else                  state_d = ST_LOW;
        end
      end
      ST_CLEAR: if (tmr_expire_c) state_d = ST_LOW;
      ST_LOW: begin
        if (tmr_expire_c) begin
          state_d = ((rem_q == '0) && (HALF == 32'd1)) ? ST_TAIL : ST_HIGH;
        end
      end
      ST_HIGH: if (tmr_expire_c) state_d = (rem_q != '0) ? ST_LOW : ST_TAIL;
      ST_TAIL: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and next output values, all derived from the upcoming state.
  always_comb begin
    accept    = (state_q == ST_IDLE) && start;
    enter_low = (state_d == ST_LOW) && (state_q != ST_LOW);
    rem_d     = accept ? count : rem_q;
    sent_d    = accept ? '0 : sent_q;
    if (enter_low) begin
      rem_d  = rem_d - WIDTH'(1);
      sent_d = sent_d + WIDTH'(1);
    end
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_CLEAR: tmr_val = CLR_LD;
      ST_HIGH:  tmr_val = (rem_q == '0) ? HALF_LAST_LD : HALF_LD;
      default:  tmr_val = HALF_LD;
    endcase
    pulse_a_d = (state_d == ST_LOW) ? ~PULSE_IDLE_LEVEL : PULSE_IDLE_LEVEL;
    clr_d     = (state_d == ST_CLEAR);
    done_d    = (state_d == ST_DONE);
    ready_d   = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      sent_q    <= '0;
      pulse_a_q <= PULSE_IDLE_LEVEL;
      pulse_b_q <= PULSE_IDLE_LEVEL;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      rem_q     <= rem_d;
      sent_q    <= sent_d;
      pulse_a_q <= pulse_a_d;
      pulse_b_q <= pulse_a_q;
      clr_q     <= clr_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign pulse_a = pulse_a_q;
  assign pulse_b = pulse_b_q;
  assign r0      = clr_q;
  assign r1      = clr_q;
  assign done    = done_q;
  assign ready   = ready_q;
  assign sent    = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle expected outputs queued at stimulus, popped at sampling.
module tb_pulse_train_gen;

  localparam int WIDTH = 8;
  localparam int HALF  = 1;
  localparam int CLR   = 2;

  typedef logic [WIDTH+5:0] obs_t;  // {pulse_a, pulse_b, r0, r1, done, ready, sent}

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] count;
  logic             clear_first;
  logic             ready, done, pulse_a, pulse_b, r0, r1;
  logic [WIDTH-1:0] sent;

  obs_t exp_q[$];
  obs_t obs;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Behavioural SN74XX93: clka <- pulse_a, clkb <- qa (ripple), async clear when r0 & r1.
  logic qa = 1'b0, qb = 1'b0, qc = 1'b0, qd = 1'b0;
  logic clr74;
  assign clr74 = r0 & r1;
  always @(negedge pulse_a or posedge clr74) if (clr74) qa <= 1'b0; else qa <= ~qa;
  always @(negedge qa or posedge clr74)      if (clr74) qb <= 1'b0; else qb <= ~qb;
  always @(negedge qb or posedge clr74)      if (clr74) qc <= 1'b0; else qc <= ~qc;
  always @(negedge qc or posedge clr74)      if (clr74) qd <= 1'b0; else qd <= ~qd;

  pulse_train_gen #(.WIDTH(WIDTH), .HALF(HALF), .CLR_CYCLES(CLR)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .count       (count),
    .clear_first (clear_first),
    .ready       (ready),
    .done        (done),
    .pulse_a     (pulse_a),
    .pulse_b     (pulse_b),
    .r0          (r0),
    .r1          (r1),
    .sent        (sent)
  );

  always #5 clk = ~clk;

  assign obs = {pulse_a, pulse_b, r0, r1, done, ready, sent};

  function automatic obs_t mk(logic pa, logic pb, logic r, logic dn, logic rdy, int s);
    return {pa, pb, r, r, dn, rdy, WIDTH'(s)};
  endfunction

  function automatic obs_t idle_vec(int s);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, s);
  endfunction

  // Expected outputs for cycles 1..done+1 after the accept edge; returns the done cycle.
  task automatic push_burst(input int n, input bit clr, output int dc);
    int   off, s;
    logic pa, prev;
    off  = (clr && n > 0) ? CLR : 0;
    dc   = (n == 0) ? 1 : off + 2 * HALF * n + 1;
    prev = 1'b1;
    for (int j = 1; j <= dc + 1; j++) begin
      pa = 1'b1;
      if (n > 0 && j > off && j <= off + 2 * HALF * n && ((j - off - 1) % (2 * HALF)) < HALF)
        pa = 1'b0;
      if (n == 0 || j <= off) s = 0;
      else begin
        s = (j - off - 1) / (2 * HALF) + 1;
        if (s > n) s = n;
      end
      exp_q.push_back(mk(pa, prev, (n > 0 && clr && j <= off), (j == dc), (j > dc), s));
      prev = pa;
    end
  endtask

  task automatic check_cycles(input int k, input string tag);
    obs_t e;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      n_assert++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
      end else begin
        e = exp_q.pop_front();
        assert (obs === e) else begin
          n_fail++;
          $error("FAIL %s cyc%0d: observed %h expected %h", tag, i, obs, e);
        end
      end
    end
  endtask

  task automatic burst(input int n, input bit clr, input bit hold, input string tag);
    int dc;
    count       = WIDTH'(n);
    clear_first = clr;
    start       = 1'b1;
    push_burst(n, clr, dc);
    if (hold) begin
      check_cycles(dc, tag);
      start = 1'b0;
      check_cycles(1, tag);
    end else begin
      check_cycles(1, tag);
      start = 1'b0;
      check_cycles(dc, tag);
    end
  endtask

  task automatic check_ctr(input logic [3:0] want, input string tag);
    n_assert++;
    assert ({qd, qc, qb, qa} === want) else begin
      n_fail++;
      $error("FAIL %s: counter observed %b expected %b", tag, {qd, qc, qb, qa}, want);
    end
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; count = '0; clear_first = 1'b0;
    repeat (2) exp_q.push_back(idle_vec(0));
    check_cycles(2, "reset");
    rst = 1'b0;
    exp_q.push_back(idle_vec(0));
    check_cycles(1, "post_reset");

    burst(5, 1'b0, 1'b0, "T1_n5");
    burst(0, 1'b0, 1'b0, "T2_n0");
    burst(0, 1'b1, 1'b0, "T2_n0_clr");
    burst(3, 1'b1, 1'b0, "T3_clr_n3");
    burst(1, 1'b0, 1'b0, "n1");

    // Abort after the third falling edge of a 10-pulse burst.
    count = WIDTH'(10); clear_first = 1'b0; start = 1'b1;
    push_burst(10, 1'b0, dc);
    check_cycles(1, "T4_run");
    start = 1'b0;
    check_cycles(4, "T4_run");
    rst = 1'b1;
    exp_q.delete();
    repeat (3) exp_q.push_back(idle_vec(0));
    check_cycles(1, "T4_rst");
    rst = 1'b0;
    check_cycles(2, "T4_after");

    burst(4, 1'b0, 1'b1, "T5_hold_start");
    exp_q.push_back(idle_vec(4));
    check_cycles(1, "T5_idle");

    burst(11, 1'b1, 1'b0, "T6_a");
    check_ctr(4'b1011, "T6_ctr11");
    burst(16, 1'b0, 1'b0, "T6_b");
    check_ctr(4'b1011, "T6_ctr_wrap");

    burst(255, 1'b0, 1'b0, "max_count");
    exp_q.push_back(idle_vec(255));
    check_cycles(1, "sent_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
